// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcode and execute-stage state types
package cpu_pkg;
  typedef enum logic [3:0] {
    ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4, NOT = 4'd5,
    PASS = 4'd6, SHL = 4'd7, SHR = 4'd8, MUL = 4'd9, CMP = 4'd10
  } alu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} exec_state_t;
endpackage

// File: rtl/execute_unit_if.sv
// execute_unit_if: issue handshake and register-file write-back bundle
interface execute_unit_if #(parameter int REG_ADDR_WIDTH = 4, parameter int DATA_WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [3:0] op;
  logic [DATA_WIDTH-1:0] opa;
  logic [DATA_WIDTH-1:0] opb;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic rd_we;
  logic wb_en;
  logic [REG_ADDR_WIDTH-1:0] wb_reg;
  logic [DATA_WIDTH-1:0] wb_data;
  logic flag_z;
  logic flag_c;
  logic flag_n;
  logic busy;
  modport master (output in_valid, op, opa, opb, rd, rd_we,
                  input in_ready, wb_en, wb_reg, wb_data, flag_z, flag_c, flag_n, busy);
  modport slave (input in_valid, op, opa, opb, rd, rd_we,
                 output in_ready, wb_en, wb_reg, wb_data, flag_z, flag_c, flag_n, busy);
endinterface

// File: rtl/execute_unit_alu_core.sv
// alu_core: combinational single-cycle ALU ops; MUL and undefined opcodes yield 0
module alu_core import cpu_pkg::*; #(parameter int W = 8) (
  input  alu_op_t        op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output logic           carry
);
  logic [W:0] sum;
  logic [W:0] diff;
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    result = '0;
    carry = 1'b0;
    case (op)
      ADD:      {carry, result} = sum;
      SUB, CMP: {carry, result} = diff;
      AND:      result = a & b;
      OR:       result = a | b;
      XOR:      result = a ^ b;
      NOT:      result = ~a;
      PASS:     result = b;
      SHL:      {carry, result} = {a, 1'b0};
      SHR:      {result, carry} = {1'b0, a};
      default:  ;
    endcase
  end
endmodule

// File: rtl/execute_unit.sv
// execute_unit: execute stage with FSM, iterative shift-add MUL and write-back pulse
module execute_unit import cpu_pkg::*; #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  execute_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  exec_state_t state, state_nx;
  alu_op_t op_q;
  logic [W-1:0] a_q, b_q, wb_data_q, alu_res, res;
  logic [REG_ADDR_WIDTH-1:0] rd_q, wb_reg_q;
  logic rd_we_q, alu_c, res_c, accept, last, wb;
  logic [2*W-1:0] acc;
  logic [CW-1:0] cnt;
  logic [2:0] flags_q, flags_nx;
  assign accept = bus.in_valid && state == S_IDLE;
  assign last = cnt == CW'(W - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == S_IDLE ? (accept ? (alu_op_t'(bus.op) == MUL ? S_MUL : S_DONE) : S_IDLE) :
               state == S_MUL  ? (last ? S_DONE : S_MUL) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= ADD;
      a_q <= '0;
      b_q <= '0;
      rd_q <= '0;
      rd_we_q <= 1'b0;
      acc <= '0;
      cnt <= '0;
      wb_reg_q <= '0;
      wb_data_q <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        op_q <= alu_op_t'(bus.op);
        a_q <= bus.opa;
        b_q <= bus.opb;
        rd_q <= bus.rd;
        rd_we_q <= bus.rd_we;
        acc <= '0;
        cnt <= '0;
      end
      if (state == S_MUL) begin
        acc <= acc + (a_q[cnt] ? {{W{1'b0}}, b_q} << cnt : '0);
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (state == S_DONE) begin
        flags_q <= flags_nx;
        if (rd_we_q) begin
          wb_reg_q <= rd_q;
          wb_data_q <= res;
        end
      end
    end
  end
  alu_core #(.W(W)) u_alu (.op(op_q), .a(a_q), .b(b_q), .result(alu_res), .carry(alu_c));
  // MUL result lives in the accumulator; overflow is any bit in its high half
  assign res = op_q == MUL ? acc[W-1:0] : alu_res;
  assign res_c = op_q == MUL ? |acc[2*W-1:W] : alu_c;
  assign flags_nx = {res == '0, res_c, res[W-1]};
  always_comb begin
    wb = state == S_DONE && rd_we_q;
    bus.in_ready = state == S_IDLE;
    bus.busy = state != S_IDLE;
    bus.wb_en = wb;
    bus.wb_reg = wb ? rd_q : wb_reg_q;
    bus.wb_data = wb ? res : wb_data_q;
    {bus.flag_z, bus.flag_c, bus.flag_n} = state == S_DONE ? flags_nx : flags_q;
  end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: randomized and directed checks against an arithmetic reference model
module tb_execute_unit;
  import cpu_pkg::*;
  localparam int AW = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  execute_unit_if #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(W)) bus();
  execute_unit #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int wb_pulses = 0;
  int exp_pulses = 0;
  logic [W-1:0] m_data = '0;
  logic [AW-1:0] m_reg = '0;
  logic [2:0] m_flags = '0;
  always @(negedge clk) if (bus.wb_en) wb_pulses++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // returns {carry, result} straight from the arithmetic definition of each op
  function automatic logic [8:0] model(input int op, input int a, input int b);
    int r, c;
    r = 0;
    c = 0;
    case (op)
      0: begin r = a + b; c = r > 255 ? 1 : 0; end
      1, 10: begin r = a - b; c = a < b ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = b;
      7: begin r = a * 2; c = a >= 128 ? 1 : 0; end
      8: begin r = a / 2; c = a % 2; end
      9: begin r = a * b; c = r > 255 ? 1 : 0; end
      default: ;
    endcase
    return {c != 0, 8'(r & 255)};
  endfunction
  task automatic drive(input int op, input int a, input int b, input int rd, input bit we);
    bus.op = 4'(op);
    bus.opa = 8'(a);
    bus.opb = 8'(b);
    bus.rd = 4'(rd);
    bus.rd_we = we;
  endtask
  task automatic run_op(input bit hold, input int nop, input int na, input int nb, input int nrd, input bit nwe);
    int op, a, b, rd, lat, n;
    bit we;
    logic [8:0] m;
    op = int'(bus.op);
    a = int'(bus.opa);
    b = int'(bus.opb);
    rd = int'(bus.rd);
    we = bus.rd_we;
    n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", n < 50, 1);
    m = model(op, a, b);
    lat = op == 9 ? W + 1 : 1;
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) drive(nop, na, nb, nrd, nwe);
        else bus.in_valid = 1'b0;
      end
      if (k <= lat) check("busy_ready", bus.in_ready, 0);
      if (k < lat) check("early_wb", bus.wb_en, 0);
      if (k == lat) begin
        if (we) begin
          m_data = m[7:0];
          m_reg = 4'(rd);
          exp_pulses++;
        end
        m_flags = {m[7:0] == 8'h00, m[8], m[7]};
        check("wb_en", bus.wb_en, we);
        check("wb_reg", bus.wb_reg, m_reg);
        check("wb_data", bus.wb_data, m_data);
        check("flags", {bus.flag_z, bus.flag_c, bus.flag_n}, m_flags);
      end
      if (k == lat + 1) begin
        check("ready_after", bus.in_ready, 1);
        check("wb_low", bus.wb_en, 0);
        check("hold_data", bus.wb_data, m_data);
        check("hold_flags", {bus.flag_z, bus.flag_c, bus.flag_n}, m_flags);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int p, nop, na, nb, nrd;
    bit nwe, h;
    bus.in_valid = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_wb_en", bus.wb_en, 0);
    check("rst_wb_reg", bus.wb_reg, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_flags", {bus.flag_z, bus.flag_c, bus.flag_n}, 0);
    rst = 1'b0;
    @(negedge clk);
    drive(ADD, 8'hF0, 8'h20, 3, 1); run_op(0, 0, 0, 0, 0, 0);
    check("add_data", bus.wb_data, 8'h10);
    check("add_c", bus.flag_c, 1);
    drive(CMP, 5, 5, 2, 0); run_op(0, 0, 0, 0, 0, 0);
    check("cmp_z", bus.flag_z, 1);
    check("cmp_keep", bus.wb_data, 8'h10);
    drive(SUB, 3, 4, 1, 1); run_op(0, 0, 0, 0, 0, 0);
    check("sub_data", bus.wb_data, 8'hFF);
    check("sub_cn", {bus.flag_c, bus.flag_n}, 2'b11);
    drive(MUL, 8'h10, 8'h11, 7, 1); run_op(0, 0, 0, 0, 0, 0);
    check("mul_data", bus.wb_data, 8'h10);
    check("mul_c", bus.flag_c, 1);
    drive(MUL, 8'h0F, 8'h0F, 7, 1); run_op(0, 0, 0, 0, 0, 0);
    check("mul2_data", bus.wb_data, 8'hE1);
    drive(SHL, 8'h81, 0, 4, 1); run_op(0, 0, 0, 0, 0, 0);
    check("shl_data", bus.wb_data, 8'h02);
    drive(SHR, 8'h01, 0, 5, 1); run_op(0, 0, 0, 0, 0, 0);
    check("shr_zc", {bus.flag_z, bus.flag_c}, 2'b11);
    drive(15, 8'h55, 8'h66, 6, 1); run_op(0, 0, 0, 0, 0, 0);
    check("undef_data", bus.wb_data, 0);
    drive(MUL, 8'h23, 8'h45, 8, 1); run_op(1, ADD, 8'h01, 8'h02, 9, 1);
    run_op(0, 0, 0, 0, 0, 0);
    check("b2b_data", bus.wb_data, 8'h03);
    drive(MUL, 8'hFF, 8'hFF, 10, 1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    p = wb_pulses;
    rst = 1'b1;
    #1;
    check("mid_rst_wb", bus.wb_en, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_flags", {bus.flag_z, bus.flag_c, bus.flag_n}, 0);
    m_data = '0;
    m_reg = '0;
    m_flags = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_wb_after_rst", wb_pulses, p);
    drive($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    repeat (150) begin
      nop = $urandom_range(0, 15);
      na = $urandom_range(0, 255);
      nb = $urandom_range(0, 255);
      nrd = $urandom_range(0, 15);
      nwe = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      run_op(h, nop, na, nb, nrd, nwe);
      if (!h) drive(nop, na, nb, nrd, nwe);
    end
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pulse_count", wb_pulses, exp_pulses);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
